// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory: round-robin
// grant with a lock for port 1, and a latency-matched read-return pipeline.
//
// state | meaning
// ARB   | round-robin between req0 and req1, last-granted loses ties
// OWN1  | port 1 holds the memory while lock1_i is high; req0 is never granted

module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 14,
   parameter int NB_COL       = 4,
   parameter int READ_LATENCY = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req0_i,
   input  logic [NB_COL-1:0]       we0_i,
   input  logic [ADDR_WIDTH-1:0]   addr0_i,
   input  logic [NB_COL*8-1:0]     wdata0_i,
   input  logic                    req1_i,
   input  logic [NB_COL-1:0]       we1_i,
   input  logic [ADDR_WIDTH-1:0]   addr1_i,
   input  logic [NB_COL*8-1:0]     wdata1_i,
   input  logic                    lock1_i,
   output logic                    gnt0_o,
   output logic                    gnt1_o,
   output logic                    rvalid0_o,
   output logic [NB_COL*8-1:0]     rdata0_o,
   output logic                    rvalid1_o,
   output logic [NB_COL*8-1:0]     rdata1_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [NB_COL*8-1:0]     mem_din_o,
   output logic [NB_COL-1:0]       mem_we_o,
   output logic                    mem_en_o,
   input  logic [NB_COL*8-1:0]     mem_dout_i
);

   typedef enum logic {ARB, OWN1} state_t;

   state_t                  state;
   logic                    last;
   logic                    gnt0;
   logic                    gnt1;
   logic                    rd_push;
   logic [READ_LATENCY-1:0] pipe_vld;
   logic [READ_LATENCY-1:0] pipe_id;
   logic                    ret_vld;
   logic                    ret_id;
   logic [NB_COL*8-1:0]     hold0;
   logic [NB_COL*8-1:0]     hold1;

   // last=1 means port 1 was granted most recently, so port 0 wins a tie
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst_i) begin
         if (state == OWN1) begin
            gnt1 = req1_i;
         end else if (req0_i && req1_i) begin
            if (last) gnt0 = 1'b1;
            else      gnt1 = 1'b1;
         end else begin
            gnt0 = req0_i;
            gnt1 = req1_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ARB;
         last  <= 1'b1;
      end else begin
         if (gnt0 || gnt1) last <= gnt1;
         case (state)
            ARB:     if (gnt1 && lock1_i) state <= OWN1;
            OWN1:    if (!lock1_i)        state <= ARB;
            default:                      state <= ARB;
         endcase
      end
   end

   assign gnt0_o     = gnt0;
   assign gnt1_o     = gnt1;
   assign mem_en_o   = gnt0 || gnt1;
   assign mem_addr_o = gnt1 ? addr1_i  : addr0_i;
   assign mem_din_o  = gnt1 ? wdata1_i : wdata0_i;
   assign mem_we_o   = gnt1 ? we1_i : (gnt0 ? we0_i : '0);

   assign rd_push = (gnt0 && (we0_i == '0)) || (gnt1 && (we1_i == '0));

   // One stage per cycle of memory latency; the last stage lines up with mem_dout_i
   if (READ_LATENCY == 1) begin : g_pipe_l1
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
         end else begin
            pipe_vld <= rd_push;
            pipe_id  <= gnt1;
         end
      end
   end else begin : g_pipe_ln
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
         end else begin
            pipe_vld <= {pipe_vld[READ_LATENCY-2:0], rd_push};
            pipe_id  <= {pipe_id[READ_LATENCY-2:0], gnt1};
         end
      end
   end

   assign ret_vld   = pipe_vld[READ_LATENCY-1];
   assign ret_id    = pipe_id[READ_LATENCY-1];
   assign rvalid0_o = ret_vld && !ret_id;
   assign rvalid1_o = ret_vld && ret_id;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold0 <= '0;
         hold1 <= '0;
      end else begin
         if (rvalid0_o) hold0 <= mem_dout_i;
         if (rvalid1_o) hold1 <= mem_dout_i;
      end
   end

   assign rdata0_o = rvalid0_o ? mem_dout_i : hold0;
   assign rdata1_o = rvalid1_o ? mem_dout_i : hold1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; runs latency-2 and latency-1 instances
// side by side on identical stimulus with a scoreboard of expected read returns.

module tb_mem_port_arbiter;

   typedef struct {
      int          id;
      int          cyc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lock1 = 1'b0;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [3:0]  we0 = '0;
   logic [3:0]  we1 = '0;
   logic [13:0] addr0 = '0;
   logic [13:0] addr1 = '0;
   logic [31:0] wdata0 = '0;
   logic [31:0] wdata1 = '0;
   logic [31:0] mem_dout = '0;

   logic        gnt0_s [2];
   logic        gnt1_s [2];
   logic        rvalid0_s [2];
   logic        rvalid1_s [2];
   logic        mem_en_s [2];
   logic [31:0] rdata0_s [2];
   logic [31:0] rdata1_s [2];
   logic [31:0] mem_din_s [2];
   logic [13:0] mem_addr_s [2];
   logic [3:0]  mem_we_s [2];

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] last_d [2][2];

   mem_port_arbiter #(.ADDR_WIDTH(14), .NB_COL(4), .READ_LATENCY(2)) u_dut_l2 (
      .clk_i(clk), .rst_i(rst),
      .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
      .lock1_i(lock1),
      .gnt0_o(gnt0_s[0]), .gnt1_o(gnt1_s[0]),
      .rvalid0_o(rvalid0_s[0]), .rdata0_o(rdata0_s[0]),
      .rvalid1_o(rvalid1_s[0]), .rdata1_o(rdata1_s[0]),
      .mem_addr_o(mem_addr_s[0]), .mem_din_o(mem_din_s[0]),
      .mem_we_o(mem_we_s[0]), .mem_en_o(mem_en_s[0]),
      .mem_dout_i(mem_dout)
   );

   mem_port_arbiter #(.ADDR_WIDTH(14), .NB_COL(4), .READ_LATENCY(1)) u_dut_l1 (
      .clk_i(clk), .rst_i(rst),
      .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
      .lock1_i(lock1),
      .gnt0_o(gnt0_s[1]), .gnt1_o(gnt1_s[1]),
      .rvalid0_o(rvalid0_s[1]), .rdata0_o(rdata0_s[1]),
      .rvalid1_o(rvalid1_s[1]), .rdata1_o(rdata1_s[1]),
      .mem_addr_o(mem_addr_s[1]), .mem_din_o(mem_din_s[1]),
      .mem_we_o(mem_we_s[1]), .mem_en_o(mem_en_s[1]),
      .mem_dout_i(mem_dout)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory read data is a known function of the cycle index
   function automatic logic [31:0] dout_fn(input int c);
      logic [31:0] cc;
      cc = 32'(c);
      return 32'h5A00_0000 + cc * 32'h0001_0101;
   endfunction

   initial forever begin
      @(posedge clk);
      #1 mem_dout = dout_fn(cyc);
   end

   function automatic int lat(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic int sb_size(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic void sb_push(input int k, input exp_t e);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   function automatic exp_t sb_pop(input int k);
      if (k == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   function automatic int sb_front_cyc(input int k);
      return (k == 0) ? q0[0].cyc : q1[0].cyc;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic rs, input logic lk,
                       input logic r0, input logic [3:0] w0, input logic [13:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] w1, input logic [13:0] a1, input logic [31:0] d1,
                       input logic eg0, input logic eg1);
      exp_t e;
      @(posedge clk);
      #1;
      rst = rs;  lock1 = lk;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      if (rs) begin
         q0.delete();
         q1.delete();
      end
      #3;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_L%0d_gnt0", tag, lat(k)), 32'(gnt0_s[k]), 32'(eg0));
         chk($sformatf("%s_L%0d_gnt1", tag, lat(k)), 32'(gnt1_s[k]), 32'(eg1));
         chk($sformatf("%s_L%0d_mem_en", tag, lat(k)), 32'(mem_en_s[k]), 32'(eg0 | eg1));
         if (eg0 || eg1) begin
            chk($sformatf("%s_L%0d_mem_addr", tag, lat(k)), 32'(mem_addr_s[k]), 32'(eg1 ? a1 : a0));
            chk($sformatf("%s_L%0d_mem_we", tag, lat(k)), 32'(mem_we_s[k]), 32'(eg1 ? w1 : w0));
            if ((eg1 ? w1 : w0) != 4'b0000)
               chk($sformatf("%s_L%0d_mem_din", tag, lat(k)), mem_din_s[k], eg1 ? d1 : d0);
         end else begin
            chk($sformatf("%s_L%0d_mem_we_idle", tag, lat(k)), 32'(mem_we_s[k]), 32'h0);
         end
         if ((eg0 && w0 == 4'b0000) || (eg1 && w1 == 4'b0000)) begin
            e.id   = eg1 ? 1 : 0;
            e.cyc  = cyc + lat(k);
            e.data = dout_fn(cyc + lat(k));
            sb_push(k, e);
         end
      end
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++)
         step(tag, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 1'b0);
   endtask

   // Return monitor: checks every rvalid against the scoreboard and rdata hold behaviour
   initial begin
      logic        rv;
      logic [31:0] rd;
      exp_t        e;
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++) last_d[k][p] = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
               rv = (p == 1) ? rvalid1_s[k] : rvalid0_s[k];
               rd = (p == 1) ? rdata1_s[k]  : rdata0_s[k];
               if (rst) begin
                  chk($sformatf("rst_L%0d_rvalid%0d", lat(k), p), 32'(rv), 32'h0);
                  chk($sformatf("rst_L%0d_rdata%0d", lat(k), p), rd, 32'h0);
                  last_d[k][p] = '0;
               end else if (rv) begin
                  chk($sformatf("ret_L%0d_port%0d_expected", lat(k), p), 32'(sb_size(k) != 0), 32'h1);
                  if (sb_size(k) != 0) begin
                     e = sb_pop(k);
                     chk($sformatf("ret_L%0d_id", lat(k)), 32'(p), 32'(e.id));
                     chk($sformatf("ret_L%0d_cycle", lat(k)), 32'(cyc), 32'(e.cyc));
                     chk($sformatf("ret_L%0d_rdata%0d", lat(k), p), rd, e.data);
                     last_d[k][p] = e.data;
                  end
               end else begin
                  chk($sformatf("hold_L%0d_rdata%0d", lat(k), p), rd, last_d[k][p]);
               end
            end
            if (!rst && sb_size(k) != 0 && sb_front_cyc(k) < cyc) begin
               chk($sformatf("ret_L%0d_missing", lat(k)), 32'(cyc), 32'(sb_front_cyc(k)));
               e = sb_pop(k);
            end
         end
      end
   end

   initial begin
      // reset held with a request pending: nothing may be granted
      step("rst_a", 1, 0, 1, 4'h0, 14'h0010, 32'h0, 0, 4'h0, 14'h0, 32'h0, 0, 0);
      step("rst_b", 1, 0, 1, 4'h0, 14'h0010, 32'h0, 1, 4'h0, 14'h0110, 32'h0, 0, 0);
      step("post_rst", 0, 0, 0, 4'h0, 14'h0, 32'h0, 0, 4'h0, 14'h0, 32'h0, 0, 0);

      step("rd0_alone", 0, 0, 1, 4'h0, 14'h0010, 32'h0, 0, 4'h0, 14'h0, 32'h0, 1, 0);
      idle("idle_a", 3);

      step("wr1", 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 4'b0011, 14'h0100, 32'hDEADBEEF, 0, 1);
      idle("idle_b", 3);

      step("rr_1", 0, 0, 1, 4'h0, 14'h0020, 32'h0, 1, 4'h0, 14'h0120, 32'h0, 1, 0);
      step("rr_2", 0, 0, 1, 4'h0, 14'h0021, 32'h0, 1, 4'h0, 14'h0121, 32'h0, 0, 1);
      step("rr_3", 0, 0, 1, 4'h0, 14'h0022, 32'h0, 1, 4'h0, 14'h0122, 32'h0, 1, 0);
      step("rr_4", 0, 0, 1, 4'h0, 14'h0023, 32'h0, 1, 4'h0, 14'h0123, 32'h0, 0, 1);
      idle("idle_c", 3);

      step("pre_lock", 0, 0, 1, 4'h0, 14'h0030, 32'h0, 0, 4'h0, 14'h0, 32'h0, 1, 0);
      step("lock_1", 0, 1, 1, 4'h0, 14'h0050, 32'h0, 1, 4'h0, 14'h0150, 32'h0, 0, 1);
      step("lock_2", 0, 1, 1, 4'h0, 14'h0050, 32'h0, 1, 4'h0, 14'h0151, 32'h0, 0, 1);
      step("lock_3", 0, 1, 1, 4'h0, 14'h0050, 32'h0, 1, 4'h0, 14'h0152, 32'h0, 0, 1);
      step("unlock", 0, 0, 1, 4'h0, 14'h0050, 32'h0, 0, 4'h0, 14'h0, 32'h0, 0, 0);
      step("after_lock", 0, 0, 1, 4'h0, 14'h0050, 32'h0, 0, 4'h0, 14'h0, 32'h0, 1, 0);
      idle("idle_d", 3);

      // read in flight when reset hits must never return
      step("rd_pre_rst", 0, 0, 1, 4'h0, 14'h0040, 32'h0, 0, 4'h0, 14'h0, 32'h0, 1, 0);
      step("mid_rst", 1, 0, 1, 4'h0, 14'h0041, 32'h0, 0, 4'h0, 14'h0, 32'h0, 0, 0);
      step("post_rst2", 0, 0, 0, 4'h0, 14'h0, 32'h0, 0, 4'h0, 14'h0, 32'h0, 0, 0);
      idle("idle_e", 3);

      step("b2b_1", 0, 0, 1, 4'h0, 14'h0060, 32'h0, 0, 4'h0, 14'h0, 32'h0, 1, 0);
      step("b2b_2", 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 4'h0, 14'h0160, 32'h0, 0, 1);
      step("b2b_3", 0, 0, 1, 4'h0, 14'h0061, 32'h0, 1, 4'h0, 14'h0161, 32'h0, 1, 0);
      step("b2b_4", 0, 0, 1, 4'h0, 14'h0062, 32'h0, 1, 4'h0, 14'h0161, 32'h0, 0, 1);
      step("b2b_5", 0, 0, 1, 4'h0, 14'h0063, 32'h0, 1, 4'h0, 14'h0162, 32'h0, 1, 0);
      step("b2b_6", 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 4'h0, 14'h0162, 32'h0, 0, 1);
      step("b2b_wr0", 0, 0, 1, 4'hF, 14'h0070, 32'h1234_5678, 0, 4'h0, 14'h0, 32'h0, 1, 0);
      step("b2b_7", 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 4'h0, 14'h0163, 32'h0, 0, 1);
      step("drop_a", 0, 0, 1, 4'h0, 14'h0064, 32'h0, 1, 4'h0, 14'h0164, 32'h0, 1, 0);
      step("drop_b", 0, 0, 0, 4'h0, 14'h0, 32'h0, 0, 4'h0, 14'h0164, 32'h0, 0, 0);
      idle("idle_f", 4);

      for (int k = 0; k < 2; k++)
         chk($sformatf("sb_L%0d_empty", lat(k)), 32'(sb_size(k)), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning the word address width.
REQ-002 SHALL have parameter NB_COL, default 4, meaning the number of byte lanes; data width is NB_COL*8.
REQ-003 SHALL have parameter READ_LATENCY, default 2, meaning the memory read latency in cycles (1..4).
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk_i  input  1  rising-edge clock; rst_i  input  1  async active-high reset.
REQ-005 SHALL have, for n in {0,1}, req<n>_i  input  1  access request (0 = core data port, 1 = loader/debug port).
REQ-006 SHALL have we<n>_i  input  NB_COL  byte write enables; all-zero means a read.
REQ-007 SHALL have addr<n>_i  input  ADDR_WIDTH  word address, and wdata<n>_i  input  NB_COL*8  write data.
REQ-008 SHALL have lock1_i  input  1, which keeps ownership with requester 1 while asserted.
REQ-009 SHALL have gnt<n>_o  output  1  request accepted this cycle.
REQ-010 SHALL have rvalid<n>_o  output  1  and rdata<n>_o  output  NB_COL*8, carrying the read return.
REQ-011 SHALL have mem_addr_o  output  ADDR_WIDTH; mem_din_o  output  NB_COL*8; mem_we_o  output  NB_COL; mem_en_o  output  1.
REQ-012 SHALL have mem_dout_i  input  NB_COL*8  memory read data.

Function
REQ-013 SHALL grant at most one requester per cycle; gnt is combinational from the req inputs and the arbiter state.
REQ-014 SHALL, when one request is present, grant it in the same cycle.
REQ-015 SHALL, when both requests are present, grant the requester not granted most recently (round-robin); after reset, requester 0 wins the first tie.
REQ-016 SHALL update the last-granted register only on a cycle with a grant.
REQ-017 SHALL keep state OWN1 while lock1_i=1 after a grant to requester 1; in OWN1, req0_i is never granted and req1_i is granted every cycle it is asserted.
REQ-018 SHALL leave OWN1 for ARB on the first cycle lock1_i=0; ARB is the reset state.
REQ-019 SHALL, in a granted cycle, drive mem_en_o=1 and mem_addr_o, mem_din_o and mem_we_o from the granted requester; otherwise mem_en_o=0 and mem_we_o=0.
REQ-020 SHALL track every granted read (we=0) in a READ_LATENCY-deep shift register of {valid, id}.
REQ-021 SHALL assert rvalid<id>_o for exactly one cycle, READ_LATENCY cycles after the grant, with rdata<id>_o = mem_dout_i in that cycle.
REQ-022 SHALL hold rdata<n>_o at its last returned value when no return is present.
REQ-023 SHALL NOT produce any rvalid for a granted write.
REQ-024 SHALL accept back-to-back reads (one per cycle, mixed ids), returning them in order with no gaps and no loss.
REQ-025 SHALL require requesters to hold req/we/addr/wdata stable until gnt; a request dropped before gnt is discarded with no memory access.

Reset
REQ-026 SHALL, while rst_i=1, force gnt*=0, rvalid*=0, rdata*=0, mem_en_o=0, mem_we_o=0 and state=ARB, and clear the shift register and last-granted (last=1, so requester 0 wins the next tie).
REQ-027 SHALL drop reads in flight when reset asserts mid-operation; no rvalid is produced for them after reset releases.
REQ-028 SHALL grant nothing in the first cycle after reset deassertion unless a req is sampled in that cycle.

Verification
REQ-029 SHALL cover: reset, then req0 read addr 0x0010 alone -> gnt0 same cycle, mem_addr_o=0x0010, mem_we_o=0; rvalid0 2 cycles later with rdata0 = mem_dout_i.
REQ-030 SHALL cover: req0 and req1 held together for 4 cycles -> grants 0,1,0,1; rvalid pulses follow in the same id order.
REQ-031 SHALL cover: req1 write we=4'b0011 addr 0x0100 wdata 0xDEADBEEF -> mem_we_o=0011, mem_din_o=0xDEADBEEF, and no rvalid on either port.
REQ-032 SHALL cover: lock1_i=1 with req1 and req0 asserted for 3 cycles -> gnt1 in all 3 cycles, gnt0=0; after lock1_i=0, gnt0 in the next cycle.
REQ-033 SHALL cover: a read granted, then rst_i pulsed 1 cycle later -> no rvalid after reset; all outputs are 0 during reset.
REQ-034 SHALL cover: READ_LATENCY=1 and back-to-back reads from both ports -> one rvalid per read, 1 cycle after its grant, in order.
